// File: rtl/mod_addsub_seq_if.sv
// Valid/ready bus for the limb-serial modular adder/subtractor.
// master drives operands and downstream ready; slave is the arithmetic block.
interface mod_addsub_seq_if #(
    parameter int WIDTH = 256
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             sub;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             valid_out;
    logic             ready_in;

    modport master (
        output a, b, p, sub, valid_in, ready_in,
        input  s, cout, valid_out, ready_out
    );

    modport slave (
        input  a, b, p, sub, valid_in, ready_in,
        output s, cout, valid_out, ready_out
    );
endinterface

// File: rtl/mod_addsub_seq.sv
// Limb-serial (a +/- b) mod p; one LIMB-bit carry chain reused for every pass.
// MOD_REDUCE_EN adds the reduction pass; without it s is the plain wrap result.
module mod_addsub_seq #(
    parameter int WIDTH = 256,
    parameter int LIMB  = 64
) (
    input logic            clk,
    input logic            reset,
    mod_addsub_seq_if.slave bus
);
    localparam int NLIMB = WIDTH / LIMB;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ARITH,
        REDUCE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             valid_q;

    logic             accept;
    logic             last;
    logic [LIMB-1:0]  opx;
    logic [LIMB-1:0]  opy;
    logic [LIMB:0]    sum;
    logic [WIDTH+LIMB-1:0] r_cat;
    logic [WIDTH-1:0] r_next;

    assign bus.ready_out = (state == IDLE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.valid_out = valid_q;

    assign accept = bus.valid_in && (state == IDLE);
    assign last   = (cnt == CW'(NLIMB - 1));

    // New limbs enter at the top so limb 0 ends up at the bottom
    assign r_cat  = {sum[LIMB-1:0], r_sh};
    assign r_next = r_cat[WIDTH+LIMB-1:LIMB];

`ifdef MOD_REDUCE_EN
    logic [WIDTH-1:0] t_sh;
    logic             raw;
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH+LIMB-1:0] t_cat;
    logic [WIDTH+LIMB-1:0] rot_cat;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] r_rot;
    logic             take_t;

    assign p_sh    = bus.p >> (int'(cnt) * LIMB);
    assign t_cat   = {sum[LIMB-1:0], t_sh};
    assign t_next  = t_cat[WIDTH+LIMB-1:LIMB];
    // r is rotated so it is intact again after the last reduce limb
    assign rot_cat = {r_sh[LIMB-1:0], r_sh};
    assign r_rot   = rot_cat[WIDTH+LIMB-1:LIMB];
    assign take_t  = sub_q ? raw : (raw | sum[LIMB]);
`else
    logic p_unused;
    assign p_unused = ^bus.p;
`endif

    always_comb begin
        opx = a_sh[LIMB-1:0];
        opy = b_sh[LIMB-1:0] ^ {LIMB{sub_q}};
`ifdef MOD_REDUCE_EN
        if (state == REDUCE) begin
            opx = r_sh[LIMB-1:0];
            opy = p_sh[LIMB-1:0] ^ {LIMB{~sub_q}};
        end
`endif
        sum = {1'b0, opx} + {1'b0, opy} + {{LIMB{1'b0}}, carry};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = ARITH;
`ifdef MOD_REDUCE_EN
            ARITH:  if (last) state_nxt = REDUCE;
            REDUCE: if (last) state_nxt = DONE;
`else
            ARITH:  if (last) state_nxt = DONE;
            REDUCE: state_nxt = IDLE;
`endif
            DONE:   if (bus.ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            sub_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef MOD_REDUCE_EN
            t_sh    <= '0;
            raw     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        sub_q <= bus.sub;
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                ARITH: begin
                    a_sh  <= a_sh >> LIMB;
                    b_sh  <= b_sh >> LIMB;
                    r_sh  <= r_next;
                    carry <= sum[LIMB];
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
`ifdef MOD_REDUCE_EN
                        raw   <= sum[LIMB] ^ sub_q;
                        carry <= ~sub_q;
`else
                        s_q     <= r_next;
                        cout_q  <= sum[LIMB] ^ sub_q;
                        valid_q <= 1'b1;
`endif
                    end
                end
`ifdef MOD_REDUCE_EN
                REDUCE: begin
                    r_sh  <= r_rot;
                    t_sh  <= t_next;
                    carry <= sum[LIMB];
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        s_q     <= take_t ? t_next : r_rot;
                        cout_q  <= raw;
                        valid_q <= 1'b1;
                    end
                end
`else
                REDUCE: ;
`endif
                DONE: begin
                    if (bus.ready_in) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed bench for mod_addsub_seq over secp256k1 p.
// Expectations follow MOD_REDUCE_EN when it is defined for the build.
module tb_mod_addsub_seq;
    localparam int W = 256;
    localparam logic [W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

`ifdef MOD_REDUCE_EN
    localparam int LAT = 8;
    localparam logic [W-1:0] E_WRAP1 = 256'd1;
    localparam logic [W-1:0] E_WRAP2 = P - 256'd2;
    localparam logic [W-1:0] E_SUB1  = P - 256'd1;
`else
    localparam int LAT = 4;
    localparam logic [W-1:0] E_WRAP1 = P + 256'd1;
    localparam logic [W-1:0] E_WRAP2 = P + P - 256'd2;
    localparam logic [W-1:0] E_SUB1  = ALL1;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mod_addsub_seq_if #(.WIDTH(W)) bus ();

    mod_addsub_seq #(.WIDTH(W), .LIMB(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, then waits (bounded) for valid_out; lat=0 on timeout
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, output logic [W-1:0] s,
                          output logic co, output int lat, output bit busy_bad);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.sub = ~sub;
        lat = 0;
        busy_bad = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_out) busy_bad = 1'b1;
            if (bus.valid_out) begin
                lat = i;
                break;
            end
        end
        s = bus.s;
        co = bus.cout;
    endtask

    task automatic release_op();
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.s !== '0) begin
            fails++;
            $display("FAIL reset_s got %h want 0", bus.s);
        end
        tests++;
        if (bus.cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_cout got %b want 0", bus.cout);
        end
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", bus.valid_out);
        end
        tests++;
        if (bus.ready_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", bus.ready_out);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        run_op(256'd1, 256'd2, 1'b0, s, co, lat, bb);
        tests++;
        if (s !== 256'd3) begin
            fails++;
            $display("FAIL add_s got %h want 3", s);
        end
        tests++;
        if (co !== 1'b0) begin
            fails++;
            $display("FAIL add_cout got %b want 0", co);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL add_latency got %0d want %0d", lat, LAT);
        end
        tests++;
        if (bb !== 1'b0) begin
            fails++;
            $display("FAIL add_ready_busy got %b want 0", bb);
        end
        release_op();
        tests++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            fails++;
            $display("FAIL add_release got v=%b r=%b want v=0 r=1",
                     bus.valid_out, bus.ready_out);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        run_op(P - 256'd1, 256'd2, 1'b0, s, co, lat, bb);
        tests++;
        if (s !== E_WRAP1 || co !== 1'b0) begin
            fails++;
            $display("FAIL wrap1 got s=%h c=%b want s=%h c=0", s, co, E_WRAP1);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL wrap1_latency got %0d want %0d", lat, LAT);
        end
        release_op();
        run_op(P - 256'd1, P - 256'd1, 1'b0, s, co, lat, bb);
        tests++;
        if (s !== E_WRAP2 || co !== 1'b1) begin
            fails++;
            $display("FAIL wrap2 got s=%h c=%b want s=%h c=1", s, co, E_WRAP2);
        end
        release_op();
    endtask

    task automatic test_sub();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        run_op(256'd1, 256'd2, 1'b1, s, co, lat, bb);
        tests++;
        if (s !== E_SUB1 || co !== 1'b1) begin
            fails++;
            $display("FAIL sub1 got s=%h c=%b want s=%h c=1", s, co, E_SUB1);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL sub1_latency got %0d want %0d", lat, LAT);
        end
        release_op();
        run_op(256'd5, 256'd3, 1'b1, s, co, lat, bb);
        tests++;
        if (s !== 256'd2 || co !== 1'b0) begin
            fails++;
            $display("FAIL sub2 got s=%h c=%b want s=2 c=0", s, co);
        end
        release_op();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        bit hold_bad;
        bit idle_bad;
        run_op(256'd1, 256'd2, 1'b0, s, co, lat, bb);
        hold_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.valid_in = (i == 2);
            bus.a = 256'd7;
            bus.b = 256'd8;
            bus.sub = 1'b0;
            @(posedge clk);
            #1;
            if (bus.s !== 256'd3 || bus.cout !== 1'b0 ||
                bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0)
                hold_bad = 1'b1;
        end
        bus.valid_in = 1'b0;
        tests++;
        if (hold_bad !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold got unstable=%b want 0", hold_bad);
        end
        release_op();
        tests++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1",
                     bus.valid_out, bus.ready_out);
        end
        idle_bad = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) idle_bad = 1'b1;
        end
        tests++;
        if (idle_bad !== 1'b0) begin
            fails++;
            $display("FAIL bp_second_accepted got %b want 0", idle_bad);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        @(negedge clk);
        bus.a = 256'd100;
        bus.b = 256'd200;
        bus.sub = 1'b0;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            fails++;
            $display("FAIL midrst got v=%b r=%b want v=0 r=1",
                     bus.valid_out, bus.ready_out);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(256'd7, 256'd8, 1'b0, s, co, lat, bb);
        tests++;
        if (s !== 256'd15 || co !== 1'b0) begin
            fails++;
            $display("FAIL midrst_op got s=%h c=%b want s=f c=0", s, co);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL midrst_latency got %0d want %0d", lat, LAT);
        end
        release_op();
    endtask

`ifndef MOD_REDUCE_EN
    task automatic test_plain();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit bb;
        run_op(ALL1, 256'd1, 1'b0, s, co, lat, bb);
        tests++;
        if (s !== '0 || co !== 1'b1) begin
            fails++;
            $display("FAIL plain_add got s=%h c=%b want s=0 c=1", s, co);
        end
        release_op();
        run_op(256'd0, 256'd1, 1'b1, s, co, lat, bb);
        tests++;
        if (s !== ALL1 || co !== 1'b1) begin
            fails++;
            $display("FAIL plain_sub got s=%h c=%b want all-ones c=1", s, co);
        end
        release_op();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        bus.a = '0;
        bus.b = '0;
        bus.p = P;
        bus.sub = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_backpressure();
        test_reset_midop();
`ifndef MOD_REDUCE_EN
        test_plain();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
